// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scan controller.
package keypad_pkg;

  typedef enum logic [2:0] {
    StScan     = 3'd0,
    StDebounce = 3'd1,
    StPress    = 3'd2,
    StHold     = 3'd3,
    StRelease  = 3'd4
  } state_t;

  // Widest column bus the priority encoder accepts.
  localparam int unsigned MaxCols = 32;

  function automatic int unsigned calc_kcw(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  // Highest set bit wins; returns 0 for an all-zero vector.
  function automatic int unsigned prio_enc_msb(input logic [MaxCols-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxCols; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parametrised-width two-flop synchroniser with asynchronous active-low reset.
module keypad_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner with press/release debounce and single-key rollover.
// Define KEYPAD_AUTOREPEAT_EN to add typematic repeat while a key is held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_ROWS        = 4,
  parameter int unsigned NUM_COLS        = 4,
  parameter int unsigned SCAN_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000,
  localparam int unsigned KCW            = calc_kcw(NUM_ROWS, NUM_COLS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_drive,
  output logic                key_valid,
  output logic [KCW-1:0]      key_code,
  output logic                key_held,
  output logic [2:0]          state_dbg
);

  localparam int unsigned RW = $clog2(NUM_ROWS);
  localparam int unsigned CW = $clog2(NUM_COLS);
  localparam int unsigned SW = $clog2(SCAN_CYCLES);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [RW-1:0] RowLast  = RW'(NUM_ROWS - 1);
  localparam logic [SW-1:0] ScanLast = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DebLast  = DW'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned PW     = $clog2(RepMax);
  localparam logic [PW-1:0] DelayLast  = PW'(REPEAT_DELAY - 1);
  localparam logic [PW-1:0] PeriodLast = PW'(REPEAT_PERIOD - 1);

  logic [PW-1:0] rep_q;
  logic          rep_first_q;
`endif

  logic [NUM_COLS-1:0] col;
  logic [CW-1:0]       col_top;
  logic                col_bit;

  state_t          state_q;
  logic [RW-1:0]   row_q;
  logic [SW-1:0]   dwell_q;
  logic [DW-1:0]   deb_q;
  logic [CW-1:0]   col_idx_q;
  logic            key_valid_q;
  logic [KCW-1:0]  key_code_q;
  logic            key_held_q;

  keypad_sync #(
    .Width(NUM_COLS)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (col_in),
    .q   (col)
  );

  assign col_top = CW'(prio_enc_msb(MaxCols'(col)));
  assign col_bit = col[col_idx_q];

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    return (r == RowLast) ? '0 : r + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StScan;
      row_q       <= '0;
      dwell_q     <= '0;
      deb_q       <= '0;
      col_idx_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        StScan: begin
          if (dwell_q == ScanLast) begin
            dwell_q <= '0;
            if (col != '0) begin
              col_idx_q <= col_top;
              deb_q     <= '0;
              state_q   <= StDebounce;
            end else begin
              row_q <= next_row(row_q);
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        StDebounce: begin
          if (!col_bit) begin
            state_q <= StScan;
            row_q   <= next_row(row_q);
          end else if (deb_q == DebLast) begin
            state_q     <= StPress;
            key_valid_q <= 1'b1;
            key_code_q  <= KCW'(row_q) * KCW'(NUM_COLS) + KCW'(col_idx_q);
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        StPress: begin
          state_q    <= StHold;
          key_held_q <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_q       <= PW'(1);
          rep_first_q <= 1'b1;
`endif
        end
        StHold: begin
          if (!col_bit) begin
            deb_q   <= '0;
            state_q <= StRelease;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_q == (rep_first_q ? DelayLast : PeriodLast)) begin
            // Same key_code is re-emitted on each repeat.
            key_valid_q <= 1'b1;
            rep_q       <= '0;
            rep_first_q <= 1'b0;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
`endif
        end
        StRelease: begin
          if (col_bit) begin
            state_q <= StHold;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= PW'(1);
            rep_first_q <= 1'b1;
`endif
          end else if (deb_q == DebLast) begin
            key_held_q <= 1'b0;
            state_q    <= StScan;
            row_q      <= next_row(row_q);
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StScan;
          row_q      <= '0;
          dwell_q    <= '0;
          deb_q      <= '0;
          key_held_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_q       <= '0;
          rep_first_q <= 1'b1;
`endif
        end
      endcase
    end
  end

  always_comb begin
    row_drive        = '0;
    row_drive[row_q] = 1'b1;
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl driven through a simple 4x4 key-matrix model.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rstn;
  logic [3:0] col_in;
  logic [3:0] row_drive;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [2:0] state_dbg;

  logic [3:0] keys [4];

  int n_cmp;
  int n_err;

  keypad_scan_ctrl #(
    .NUM_ROWS       (4),
    .NUM_COLS       (4),
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (10)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .col_in   (col_in),
    .row_drive(row_drive),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held),
    .state_dbg(state_dbg)
  );

  // Pressed key shorts its row strobe onto its column line.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++) begin
      if (row_drive[r]) col_in = col_in | keys[r];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
  endtask

  task automatic wait_scan(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (state_dbg == 3'd0) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL %s_return_scan: state_dbg=%0d required 0", name, state_dbg);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_keys();
    repeat (3) tick();
    n_cmp++;
    if (row_drive !== 4'b0001) begin
      n_err++; $display("FAIL reset_row: got %b required 0001", row_drive);
    end
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b required 0", key_valid);
    end
    n_cmp++;
    if (key_code !== 4'd0) begin
      n_err++; $display("FAIL reset_code: got %0d required 0", key_code);
    end
    n_cmp++;
    if (key_held !== 1'b0) begin
      n_err++; $display("FAIL reset_held: got %b required 0", key_held);
    end
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_err++; $display("FAIL reset_state: got %0d required 0", state_dbg);
    end
    rstn = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp;
    for (int k = 0; k <= 16; k++) begin
      exp = 4'b0001 << ((k / 4) % 4);
      n_cmp++;
      if (row_drive !== exp) begin
        n_err++; $display("FAIL idle_row[%0d]: got %b required %b", k, row_drive, exp);
      end
      n_cmp++;
      if (key_valid !== 1'b0) begin
        n_err++; $display("FAIL idle_valid[%0d]: got %b required 0", k, key_valid);
      end
      tick();
    end
  endtask

  task automatic test_single_key();
    int         pulses;
    logic [3:0] code;
    pulses = 0;
    code   = 4'hx;
    keys[2][1] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (key_valid) begin
        pulses++;
        code = key_code;
      end
    end
    n_cmp++;
    if (code !== 4'd9) begin
      n_err++; $display("FAIL single_code: got %0d required 9", code);
    end
    n_cmp++;
    if (key_held !== 1'b1) begin
      n_err++; $display("FAIL single_held: got %b required 1", key_held);
    end
    n_cmp++;
    if (state_dbg !== 3'd3) begin
      n_err++; $display("FAIL single_hold_state: got %0d required 3", state_dbg);
    end
    keys[2][1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (key_valid) pulses++;
      if (k == 6) begin
        n_cmp++;
        if (key_held !== 1'b1 || state_dbg !== 3'd4) begin
          n_err++;
          $display("FAIL single_release_mid: held=%b state=%0d required held=1 state=4",
                   key_held, state_dbg);
        end
      end
      if (k == 13) begin
        n_cmp++;
        if (key_held !== 1'b0 || state_dbg !== 3'd0) begin
          n_err++;
          $display("FAIL single_release_done: held=%b state=%0d required held=0 state=0",
                   key_held, state_dbg);
        end
      end
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL single_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_glitch();
    bit         saw_deb;
    bit         got_row;
    logic [3:0] row_after;
    int         pulses;
    saw_deb   = 1'b0;
    got_row   = 1'b0;
    row_after = 4'hx;
    pulses    = 0;
    for (int k = 0; k < 20 && row_drive == 4'b0010; k++) tick();
    for (int k = 0; k < 20 && row_drive != 4'b0010; k++) tick();
    keys[1][3] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 5) keys[1][3] = 1'b0;
      if (key_valid) pulses++;
      if (state_dbg == 3'd1) saw_deb = 1'b1;
      if (saw_deb && !got_row && state_dbg == 3'd0) begin
        got_row   = 1'b1;
        row_after = row_drive;
      end
    end
    n_cmp++;
    if (saw_deb !== 1'b1) begin
      n_err++; $display("FAIL glitch_debounce_entered: got %b required 1", saw_deb);
    end
    n_cmp++;
    if (row_after !== 4'b0100) begin
      n_err++; $display("FAIL glitch_next_row: got %b required 0100", row_after);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL glitch_pulses: got %0d required 0", pulses);
    end
  endtask

  task automatic test_release_bounce();
    bit         got;
    int         seq [8];
    int         nseq;
    int         pulses;
    int         bad_held;
    logic [2:0] prev;
    int         exp_seq [4];
    exp_seq = '{4, 3, 4, 0};
    got      = 1'b0;
    nseq     = 0;
    pulses   = 0;
    bad_held = 0;
    keys[3][2] = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (key_valid) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1 || key_code !== 4'd14) begin
      n_err++; $display("FAIL bounce_press: valid_seen=%b code=%0d required 1/14", got, key_code);
    end
    repeat (3) tick();
    prev = state_dbg;
    for (int k = 0; k < 35; k++) begin
      keys[3][2] = (k == 3 || k == 4);
      tick();
      if (key_valid) pulses++;
      if (state_dbg != 3'd0 && key_held !== 1'b1) bad_held++;
      if (state_dbg != prev && nseq < 8) begin
        seq[nseq] = int'(state_dbg);
        nseq++;
      end
      prev = state_dbg;
    end
    n_cmp++;
    if (nseq !== 4) begin
      n_err++; $display("FAIL bounce_transitions: got %0d required 4", nseq);
    end
    for (int i = 0; i < 4 && i < nseq; i++) begin
      n_cmp++;
      if (seq[i] !== exp_seq[i]) begin
        n_err++; $display("FAIL bounce_state[%0d]: got %0d required %0d", i, seq[i], exp_seq[i]);
      end
    end
    n_cmp++;
    if (bad_held !== 0) begin
      n_err++; $display("FAIL bounce_held: dropped %0d cycles required 0", bad_held);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL bounce_pulses: got %0d required 0", pulses);
    end
  endtask

  task automatic test_rollover();
    bit got;
    int pulses;
    int bad_state;
    got       = 1'b0;
    pulses    = 0;
    bad_state = 0;
    keys[0] = 4'b0101;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (key_valid) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1 || key_code !== 4'd2) begin
      n_err++; $display("FAIL rollover_code: valid_seen=%b code=%0d required 1/2", got, key_code);
    end
    repeat (2) tick();
    keys[3][0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (key_valid) pulses++;
      if (state_dbg != 3'd3) bad_state++;
    end
    n_cmp++;
    if (pulses !== 0 || bad_state !== 0) begin
      n_err++;
      $display("FAIL rollover_ignore: pulses=%0d off_hold=%0d required 0/0", pulses, bad_state);
    end
    n_cmp++;
    if (key_code !== 4'd2 || row_drive !== 4'b0001) begin
      n_err++;
      $display("FAIL rollover_frozen: code=%0d row=%b required 2/0001", key_code, row_drive);
    end
    clear_keys();
    wait_scan("rollover");
  endtask

  task automatic test_reset_mid_press();
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    keys[1][2] = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (key_valid) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1 || key_code !== 4'd6) begin
      n_err++; $display("FAIL midrst_press: valid_seen=%b code=%0d required 1/6", got, key_code);
    end
    repeat (3) tick();
    #3;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (row_drive !== 4'b0001 || key_valid !== 1'b0 || key_code !== 4'd0 ||
        key_held !== 1'b0 || state_dbg !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_async: row=%b valid=%b code=%0d held=%b state=%0d required 0001/0/0/0/0",
               row_drive, key_valid, key_code, key_held, state_dbg);
    end
    repeat (2) tick();
    rstn = 1'b1;
    got  = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      lat++;
      if (key_valid) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1 || lat !== 16) begin
      n_err++; $display("FAIL midrst_requalify: valid_seen=%b latency=%0d required 1/16", got, lat);
    end
    n_cmp++;
    if (key_code !== 4'd6) begin
      n_err++; $display("FAIL midrst_code: got %0d required 6", key_code);
    end
    clear_keys();
    wait_scan("midrst");
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    bit got;
    int offs [8];
    int noff;
    int exp_offs [4];
    exp_offs = '{20, 30, 40, 50};
    got  = 1'b0;
    noff = 0;
    keys[2][3] = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (key_valid) got = 1'b1;
    end
    for (int off = 1; off <= 60; off++) begin
      tick();
      if (key_valid && noff < 8) begin
        offs[noff] = off;
        noff++;
      end
      if (off == 50) keys[2][3] = 1'b0;
    end
    n_cmp++;
    if (got !== 1'b1 || noff !== 4) begin
      n_err++; $display("FAIL repeat_count: first=%b repeats=%0d required 1/4", got, noff);
    end
    for (int i = 0; i < 4 && i < noff; i++) begin
      n_cmp++;
      if (offs[i] !== exp_offs[i]) begin
        n_err++; $display("FAIL repeat_offset[%0d]: got %0d required %0d", i, offs[i], exp_offs[i]);
      end
    end
    clear_keys();
    wait_scan("repeat");
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    clear_keys();
    test_reset();
    test_idle_scan();
    test_single_key();
    test_glitch();
    test_release_bounce();
    test_rollover();
    test_reset_mid_press();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Parametrised matrix-keypad controller. It drives one-hot row strobes, samples the column returns, and debounces both press and release with an internal counter. It emits a one-cycle key event with an encoded key index. It sits between the keypad pins and the display FIFO and needs no external debouncer.

Parameters:
NUM_ROWS, 4, number of driven rows (>=2)
NUM_COLS, 4, number of sensed columns (>=2)
SCAN_CYCLES, 16, clk cycles each row is driven before sampling (>=2)
DEBOUNCE_CYCLES, 20000, consecutive stable cycles needed to accept a press or a release (>=2)
REPEAT_DELAY, 500000, cycles from press to first repeat (used only with KEYPAD_AUTOREPEAT_EN)
REPEAT_PERIOD, 100000, cycles between subsequent repeats (used only with KEYPAD_AUTOREPEAT_EN)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
col_in  in  NUM_COLS  raw column returns, active-high, asynchronous to clk
row_drive  out  NUM_ROWS  one-hot row strobe, active-high
key_valid  out  1  one-cycle pulse per accepted key event
key_code  out  KCW=$clog2(NUM_ROWS*NUM_COLS)  key index = row*NUM_COLS + col
key_held  out  1  high while an accepted key remains pressed
state_dbg  out  3  state encoding for debug LEDs

Behaviour:
- Reset is asynchronous on rstn low and applies to every flop. Reset values: state=SCAN, row_drive=1 (row 0), key_valid=0, key_code=0, key_held=0, all counters=0, synchroniser flops=0.
- col_in passes through a 2-flop synchroniser. "col" below means the synchronised value. It adds 2 cycles of latency.
- Row driven in SCAN rotates only in SCAN. Outside SCAN it is frozen at the latched row.
- SCAN (dbg 0):
  - Dwell counter runs 0..SCAN_CYCLES-1 on the current row.
  - On the last dwell cycle, if col != 0: latch the row index, latch the highest-index set column (priority MSB first), clear the debounce counter, and go to DEBOUNCE.
  - Otherwise advance the row. NUM_ROWS-1 wraps to 0.
- DEBOUNCE (dbg 1):
  - While the latched column bit is 1, increment the counter.
  - If the bit drops to 0, return to SCAN and advance to the next row. No event is generated.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bit still 1, go to PRESS.
- PRESS (dbg 2):
  - Exactly one cycle.
  - key_valid=1. key_code is updated in the same cycle and holds until the next PRESS or repeat.
  - Then go to HOLD.
- HOLD (dbg 3):
  - key_held=1.
  - Other columns and rows are ignored (single-key rollover).
  - When the latched bit goes 0, clear the counter and go to RELEASE.
- RELEASE (dbg 4):
  - key_held stays 1.
  - While the bit is 0, count. If the bit returns to 1, go back to HOLD with no new event.
  - At DEBOUNCE_CYCLES-1 consecutive low cycles: key_held=0, go to SCAN, and advance the row.
- Any unencoded state returns to SCAN with row_drive=1 on the next cycle.
- Counter widths: $clog2 of the largest terminal value used. No counter wraps, because every count is terminated by a compare.
- Reset mid-press: the block returns to SCAN immediately, no key_valid is issued, and the key must re-qualify through full debounce.
- Minimum press-to-valid latency: 2 (sync) + remaining dwell + DEBOUNCE_CYCLES + 1.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: HOLD runs a repeat counter. REPEAT_DELAY cycles after PRESS, it pulses key_valid with the same key_code, then pulses again every REPEAT_PERIOD cycles. The counter clears on leaving HOLD, and RELEASE->HOLD restarts the delay.
- Undefined: the repeat logic and REPEAT_* parameters are unused, and exactly one key_valid is issued per press.

Decomposition:
- Package keypad_pkg holds:
  - the state_t enum (SCAN=0, DEBOUNCE=1, PRESS=2, HOLD=3, RELEASE=4, 3-bit)
  - a localparam function computing KCW
  - a priority-encode function returning the highest set column index
- One sub-module, keypad_sync: a parametrised-width 2-flop synchroniser with async active-low reset.

Test Plan:
All scenarios use NUM_ROWS=4, NUM_COLS=4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
1. Idle, col_in=0: row_drive cycles 0001->0010->0100->1000->0001, 4 cycles each. key_valid never asserts.
2. Key at row 2, col 1, held 40 cycles: exactly one key_valid pulse with key_code=9. key_held asserts after PRESS and falls 8 stable-low cycles after release.
3. 5-cycle glitch on row 1, col 3: DEBOUNCE aborts to SCAN, no key_valid, and the next row driven is 0100.
4. Bounce on release (low 3, high 2, low 10): a single event only. key_held stays 1 through the bounce, and state_dbg goes 4->3->4->0.
5. Row 0 with cols 0 and 2 pressed together: key_code=2. Pressing row 3, col 0 during HOLD is ignored.
6. rstn low during HOLD: all outputs return to reset values asynchronously. After release of reset, the still-held key produces a new key_valid only after full debounce.
   With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10, and a 50-cycle hold: pulses occur at PRESS, +20, +30, +40, +50.
